uart_tx_scheduler: RTL and testbench
====================================

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- START_TIMEOUT, 15, cycles allowed for tx_busy to rise after a tx_valid pulse.
- DATA_WIDTH, 8, UART byte width.
REQ-002 Ports (name direction width meaning) SHALL be, clock and reset first:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- a_valid  in  1  requester A frame request, held until a_ack.
- a_data  in  16  requester A payload.
- a_two_byte  in  1  1 = send 2 bytes, 0 = send a_data[7:0] only.
- b_valid / b_data / b_two_byte  in  1/16/1  requester B, same meaning.
- tx_busy  in  1  busy flag from the UART TX.
- a_ack, b_ack  out  1  one-cycle grant/capture pulse.
- tx_valid  out  1  one-cycle byte-start pulse to the UART TX.
- tx_data  out  8  byte presented to the UART TX.
- sched_busy  out  1  high in every state except IDLE.
- grant_id  out  1  owner of the current frame (0 = A, 1 = B).
- tx_err  out  1  one-cycle pulse on start timeout.

Function
REQ-003 The block SHALL use states IDLE, ISSUE, WAIT_START and WAIT_DONE.
REQ-004 Arbitration in IDLE:
- Only A valid -> grant A; only B valid -> grant B.
- Both valid -> grant the requester not granted last (round-robin).
REQ-005 On grant in IDLE, the block SHALL, in that same cycle:
- Assert the granted ack combinationally.
- Latch data into a 16-bit hold register.
- Set bytes_left = two_byte ? 2 : 1.
- Update last_grant and grant_id, then go to ISSUE.
REQ-006 Ack SHALL never be asserted outside IDLE; a_ack and b_ack SHALL never be high together.
REQ-007 ISSUE: if tx_busy = 0, assert tx_valid for exactly one cycle and go to WAIT_START; if tx_busy = 1, hold tx_valid low and stay in ISSUE.
REQ-008 tx_data SHALL be registered as hold[7:0] and stay stable from ISSUE entry until the next byte's ISSUE or return to IDLE.
REQ-009 WAIT_START:
- tx_busy = 1 -> go to WAIT_DONE.
- Otherwise increment the timeout counter.
- On START_TIMEOUT cycles without busy: pulse tx_err, drop the remaining bytes, go to IDLE.
REQ-010 WAIT_DONE: wait for tx_busy = 0, then:
- bytes_left = 2 -> shift hold right by 8, set bytes_left = 1, go to ISSUE.
- Otherwise go to IDLE.
REQ-011 Bytes SHALL be sent LSB first; a two-byte frame SHALL never be interleaved with the other requester.
REQ-012 A request that arrives while sched_busy = 1 SHALL wait, unacked, until IDLE.
REQ-013 Minimum latency from a_valid (with the scheduler in IDLE and tx_busy = 0) to tx_valid SHALL be 1 cycle.
REQ-014 The timeout counter SHALL clear on every entry to WAIT_START and SHALL saturate, never wrap.

Reset
REQ-015 While rst = 1 at a clk edge, the block SHALL:
- Go to IDLE.
- Clear bytes_left, hold and the timeout counter.
- Set last_grant = B, so A wins the first contention.
REQ-016 During reset, outputs SHALL be: tx_valid = 0, tx_data = 0, a_ack = b_ack = 0, sched_busy = 0, grant_id = 0, tx_err = 0.
REQ-017 Reset in mid-frame SHALL abandon the frame with no further tx_valid pulse; the first post-reset cycle SHALL be a normal IDLE.

Structure
REQ-018 The state encoding (IDLE = 2'b00, ISSUE = 2'b01, WAIT_START = 2'b10, WAIT_DONE = 2'b11) and the START_TIMEOUT default SHALL live in the shared package uart_sched_pkg.
REQ-019 The two-way round-robin grant logic SHALL be the single sub-module uart_sched_rr_arb, with inputs req[1:0] and last_grant, and outputs gnt[1:0].

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Single byte: a_valid = 1, a_data = 16'h12A5, a_two_byte = 0, model busy high for 10 cycles -> a_ack 1 cycle, one tx_valid with tx_data = 8'hA5, then IDLE.
- Two bytes: b_data = 16'hBEEF, b_two_byte = 1 -> tx_data 8'hEF, then 8'hBE after busy falls; b_ack once.
- Contention: a_valid and b_valid both high from reset, each with 1 byte -> A granted first, then B; grant_id 0 then 1.
- Timeout: tx_busy held 0 after tx_valid -> tx_err pulses 15 cycles later; second byte of a two-byte frame never sent.
- Reset mid-frame: assert rst in WAIT_DONE of the first byte of 16'hCAFE -> no 8'hCA issued; outputs at reset values.
- Busy at issue: tx_busy = 1 on entering ISSUE -> tx_valid withheld until busy = 0, then a single pulse.

Source files
------------

// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_sched_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    ISSUE      = 2'b01,
    WAIT_START = 2'b10,
    WAIT_DONE  = 2'b11
  } sched_state_e;

  localparam int unsigned START_TIMEOUT_DEFAULT = 15;
  localparam int unsigned FRAME_WIDTH           = 16;

  localparam logic GRANT_A = 1'b0;
  localparam logic GRANT_B = 1'b1;

  // Number of bytes carried by a frame request.
  function automatic logic [1:0] frame_bytes(input logic two_byte);
    return two_byte ? 2'd2 : 2'd1;
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Requester and UART TX side signals of the scheduler.
interface uart_tx_scheduler_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  import uart_sched_pkg::*;

  logic                   a_valid;
  logic [FRAME_WIDTH-1:0] a_data;
  logic                   a_two_byte;
  logic                   b_valid;
  logic [FRAME_WIDTH-1:0] b_data;
  logic                   b_two_byte;
  logic                   tx_busy;
  logic                   a_ack;
  logic                   b_ack;
  logic                   tx_valid;
  logic [DATA_WIDTH-1:0]  tx_data;
  logic                   sched_busy;
  logic                   grant_id;
  logic                   tx_err;

  modport slave (
    input  a_valid, a_data, a_two_byte,
    input  b_valid, b_data, b_two_byte,
    input  tx_busy,
    output a_ack, b_ack, tx_valid, tx_data, sched_busy, grant_id, tx_err
  );

  modport master (
    output a_valid, a_data, a_two_byte,
    output b_valid, b_data, b_two_byte,
    output tx_busy,
    input  a_ack, b_ack, tx_valid, tx_data, sched_busy, grant_id, tx_err
  );

endinterface

// File: rtl/uart_sched_rr_arb.sv
// Two-way round-robin arbiter: on contention the requester not granted last wins.
module uart_sched_rr_arb
  import uart_sched_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  // Grant selection from current requests and previous owner.
  always_comb begin
    gnt = '0;
    if (req[0] && (!req[1] || last_grant == GRANT_B)) begin
      gnt[0] = 1'b1;
    end else if (req[1]) begin
      gnt[1] = 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Arbitrates two frame requesters onto one UART TX, sending 1 or 2 bytes LSB first.
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int unsigned START_TIMEOUT = START_TIMEOUT_DEFAULT,
  parameter int unsigned DATA_WIDTH    = 8
) (
  input  logic                clk,
  input  logic                rst,
  uart_tx_scheduler_if.slave  bus
);

  localparam int unsigned CNT_W = (START_TIMEOUT < 2) ? 1 : $clog2(START_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(START_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TO_SAT  = CNT_W'(START_TIMEOUT);

  sched_state_e           state, state_nxt;
  logic [FRAME_WIDTH-1:0] hold;
  logic [1:0]             bytes_left;
  logic [CNT_W-1:0]       to_cnt;
  logic                   last_grant;
  logic                   grant_id_q;

  logic [1:0]             req, gnt;
  logic [FRAME_WIDTH-1:0] sel_data;
  logic                   sel_two;

  logic a_ack_c, b_ack_c, tx_valid_c, tx_err_c;
  logic load_frame, next_byte, cnt_inc, frame_end;

  assign req = {bus.b_valid, bus.a_valid};

  uart_sched_rr_arb u_arb (
    .req        (req),
    .last_grant (last_grant),
    .gnt        (gnt)
  );

  assign sel_data = gnt[1] ? bus.b_data     : bus.a_data;
  assign sel_two  = gnt[1] ? bus.b_two_byte : bus.a_two_byte;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and per-cycle strobes.
  always_comb begin
    state_nxt  = state;
    a_ack_c    = 1'b0;
    b_ack_c    = 1'b0;
    tx_valid_c = 1'b0;
    tx_err_c   = 1'b0;
    load_frame = 1'b0;
    next_byte  = 1'b0;
    cnt_inc    = 1'b0;
    frame_end  = 1'b0;
    case (state)
      IDLE: begin
        if (|gnt) begin
          a_ack_c    = gnt[0];
          b_ack_c    = gnt[1];
          load_frame = 1'b1;
          state_nxt  = ISSUE;
        end
      end
      ISSUE: begin
        if (!bus.tx_busy) begin
          tx_valid_c = 1'b1;
          state_nxt  = WAIT_START;
        end
      end
      WAIT_START: begin
        if (bus.tx_busy) begin
          state_nxt = WAIT_DONE;
        end else if (to_cnt >= TO_LAST) begin
          tx_err_c  = 1'b1;
          frame_end = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          if (bytes_left == 2'd2) begin
            next_byte = 1'b1;
            state_nxt = ISSUE;
          end else begin
            frame_end = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Frame hold register, byte count, ownership and start-timeout counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold       <= '0;
      bytes_left <= '0;
      to_cnt     <= '0;
      last_grant <= GRANT_B;
      grant_id_q <= GRANT_A;
    end else begin
      if (load_frame) begin
        hold       <= sel_data;
        bytes_left <= frame_bytes(sel_two);
        last_grant <= gnt[1];
        grant_id_q <= gnt[1];
      end else if (next_byte) begin
        hold       <= hold >> DATA_WIDTH;
        bytes_left <= 2'd1;
      end else if (frame_end) begin
        bytes_left <= '0;
      end

      // Cleared on the ISSUE->WAIT_START transition, the only way into WAIT_START.
      if (tx_valid_c) begin
        to_cnt <= '0;
      end else if (cnt_inc && to_cnt != TO_SAT) begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

  // tx_data is the low byte of the hold register, so it is registered and
  // changes only on frame load or byte shift.
  assign bus.tx_data    = hold[DATA_WIDTH-1:0];
  assign bus.grant_id   = grant_id_q;
  assign bus.a_ack      = a_ack_c    & ~rst;
  assign bus.b_ack      = b_ack_c    & ~rst;
  assign bus.tx_valid   = tx_valid_c & ~rst;
  assign bus.tx_err     = tx_err_c   & ~rst;
  assign bus.sched_busy = (state != IDLE) & ~rst;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed self-checking bench for uart_tx_scheduler with a byte scoreboard
// and a simple UART busy model.
module tb_uart_tx_scheduler;
  import uart_sched_pkg::*;

  localparam int unsigned TO = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_scheduler_if #(.DATA_WIDTH(8)) bus ();

  uart_tx_scheduler #(.START_TIMEOUT(TO), .DATA_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       id;
  } exp_t;

  exp_t sb[$];

  int vectors     = 0;
  int miscompares = 0;
  int cyc = 0;
  int busy_cnt = 0;
  int busy_len = 10;
  bit model_en = 1'b1;
  bit force_busy = 1'b0;
  bit saw_valid, saw_a_ack, saw_b_ack;
  int a_acks = 0, b_acks = 0, valids = 0, errs = 0;
  int last_ack_cyc = 0, last_valid_cyc = 0, last_err_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, want);
    end
  endtask

  // One clock: observe at the falling edge, then update requesters and
  // the busy model just after the rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    saw_valid = bus.tx_valid;
    saw_a_ack = bus.a_ack;
    saw_b_ack = bus.b_ack;
    if (saw_a_ack) begin a_acks++; last_ack_cyc = cyc; end
    if (saw_b_ack) begin b_acks++; last_ack_cyc = cyc; end
    if (saw_a_ack || saw_b_ack) begin
      chk("ack_onehot", {31'b0, saw_a_ack & saw_b_ack}, 32'd0);
      chk("ack_in_idle", {31'b0, bus.sched_busy}, 32'd0);
    end
    if (bus.tx_err) begin errs++; last_err_cyc = cyc; end
    if (saw_valid) begin
      valids++;
      last_valid_cyc = cyc;
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL unexpected_tx_valid: observed byte 0x%0h, expected no byte", bus.tx_data);
      end else begin
        e = sb.pop_front();
        chk("tx_data", {24'b0, bus.tx_data}, {24'b0, e.data});
        chk("grant_id", {31'b0, bus.grant_id}, {31'b0, e.id});
      end
    end
    @(posedge clk);
    #1;
    if (saw_a_ack) bus.a_valid = 1'b0;
    if (saw_b_ack) bus.b_valid = 1'b0;
    if (saw_valid && model_en) busy_cnt = busy_len;
    else if (busy_cnt > 0) busy_cnt--;
    bus.tx_busy = (busy_cnt != 0) || force_busy;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((bus.sched_busy || sb.size() != 0 || busy_cnt != 0 || bus.a_valid || bus.b_valid)
           && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) begin
      vectors++;
      miscompares++;
      $error("FAIL wait_idle: observed still busy after %0d cycles, expected idle", budget);
    end
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_tx_valid"},   {31'b0, bus.tx_valid},   32'd0);
    chk({pfx, "_tx_data"},    {24'b0, bus.tx_data},    32'd0);
    chk({pfx, "_a_ack"},      {31'b0, bus.a_ack},      32'd0);
    chk({pfx, "_b_ack"},      {31'b0, bus.b_ack},      32'd0);
    chk({pfx, "_sched_busy"}, {31'b0, bus.sched_busy}, 32'd0);
    chk({pfx, "_grant_id"},   {31'b0, bus.grant_id},   32'd0);
    chk({pfx, "_tx_err"},     {31'b0, bus.tx_err},     32'd0);
  endtask

  initial begin
    int base_a, base_b, base_v, base_e, n;

    rst            = 1'b1;
    bus.a_valid    = 1'b0;
    bus.a_data     = '0;
    bus.a_two_byte = 1'b0;
    bus.b_valid    = 1'b0;
    bus.b_data     = '0;
    bus.b_two_byte = 1'b0;
    bus.tx_busy    = 1'b0;

    // Contention from reset: both requesters pending while reset is held.
    bus.a_data = 16'h0033; bus.a_two_byte = 1'b0; bus.a_valid = 1'b1;
    bus.b_data = 16'h0044; bus.b_two_byte = 1'b0; bus.b_valid = 1'b1;
    tick();
    tick();
    #2;
    chk_reset_outputs("reset");
    sb.push_back('{data: 8'h33, id: 1'b0});
    sb.push_back('{data: 8'h44, id: 1'b1});
    rst = 1'b0;
    wait_idle(200);
    chk("contend_a_acks", a_acks, 1);
    chk("contend_b_acks", b_acks, 1);
    chk("contend_valids", valids, 2);

    // Single byte from A with minimum latency.
    base_a = a_acks; base_v = valids;
    bus.a_data = 16'h12A5; bus.a_two_byte = 1'b0; bus.a_valid = 1'b1;
    sb.push_back('{data: 8'hA5, id: 1'b0});
    wait_idle(200);
    chk("single_a_acks", a_acks - base_a, 1);
    chk("single_valids", valids - base_v, 1);
    chk("single_latency", last_valid_cyc - last_ack_cyc, 1);

    // Two bytes from B; A arrives mid-frame and must wait for IDLE.
    base_a = a_acks; base_b = b_acks; base_v = valids;
    bus.b_data = 16'hBEEF; bus.b_two_byte = 1'b1; bus.b_valid = 1'b1;
    sb.push_back('{data: 8'hEF, id: 1'b1});
    sb.push_back('{data: 8'hBE, id: 1'b1});
    tick();
    chk("two_busy_after_grant", {31'b0, bus.sched_busy}, 32'd1);
    bus.a_data = 16'h9911; bus.a_two_byte = 1'b0; bus.a_valid = 1'b1;
    sb.push_back('{data: 8'h11, id: 1'b0});
    wait_idle(300);
    chk("two_b_acks", b_acks - base_b, 1);
    chk("two_a_acks", a_acks - base_a, 1);
    chk("two_valids", valids - base_v, 3);

    // Start timeout: UART never raises busy; second byte must be dropped.
    model_en = 1'b0;
    base_v = valids; base_e = errs;
    bus.a_data = 16'h5A3C; bus.a_two_byte = 1'b1; bus.a_valid = 1'b1;
    sb.push_back('{data: 8'h3C, id: 1'b0});
    wait_idle(200);
    repeat (20) tick();
    chk("timeout_errs", errs - base_e, 1);
    chk("timeout_delay", last_err_cyc - last_valid_cyc, TO);
    chk("timeout_valids", valids - base_v, 1);
    model_en = 1'b1;

    // Reset while the first byte of a two-byte B frame is in flight.
    base_v = valids;
    bus.b_data = 16'hCAFE; bus.b_two_byte = 1'b1; bus.b_valid = 1'b1;
    sb.push_back('{data: 8'hFE, id: 1'b1});
    n = 0;
    while (valids == base_v && n < 20) begin tick(); n++; end
    if (valids == base_v) begin
      vectors++;
      miscompares++;
      $error("FAIL midreset_first_byte: observed no tx_valid in 20 cycles, expected one");
    end
    repeat (4) tick();
    chk("midreset_in_frame", {31'b0, bus.sched_busy}, 32'd1);
    chk("midreset_grant_id", {31'b0, bus.grant_id}, 32'd1);
    rst = 1'b1;
    tick();
    #2;
    chk_reset_outputs("midreset");
    rst = 1'b0;
    repeat (30) tick();
    chk("midreset_valids", valids - base_v, 1);
    chk("midreset_sb_empty", sb.size(), 0);

    // Busy already high when ISSUE is entered: tx_valid must wait.
    base_a = a_acks; base_v = valids;
    force_busy = 1'b1;
    bus.tx_busy = 1'b1;
    bus.a_data = 16'h0077; bus.a_two_byte = 1'b0; bus.a_valid = 1'b1;
    sb.push_back('{data: 8'h77, id: 1'b0});
    repeat (6) tick();
    chk("busyissue_withheld", valids - base_v, 0);
    chk("busyissue_a_acks", a_acks - base_a, 1);
    chk("busyissue_sched_busy", {31'b0, bus.sched_busy}, 32'd1);
    chk("busyissue_tx_data", {24'b0, bus.tx_data}, 32'h77);
    force_busy = 1'b0;
    bus.tx_busy = (busy_cnt != 0);
    wait_idle(200);
    chk("busyissue_valids", valids - base_v, 1);

    chk("total_errs", errs, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
